march_fault_classifier: RTL and testbench
=========================================

Name: march_fault_classifier

Overview:
- Self-contained march engine that tests a word-addressed RAM region with up to four data patterns and classifies every word as ok, flip (errors confined to the high-order field) or patch (any error in the low-order field).
- Successor to the fixed two-sweep ones/zeros flow, generalised in width, field split, pattern count and address range.
- Runs per-address write/read sequences and merges results across patterns internally, so no external error map is needed.
- Streams one classification per word over a valid/ready port and keeps running totals.

Parameters:
- DATA_W, 16, RAM word width (>=2)
- ADDR_W, 20, RAM address width
- HIGH_W, 8, number of MSBs forming the high-order field (1..DATA_W-1); low field = remaining LSBs
- N_PAT, 2, patterns applied per word (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  level/pulse; sampled only in IDLE or DONE
- base_addr  in  ADDR_W  first address; sampled when start is accepted
- last_addr  in  ADDR_W  last address, inclusive; sampled when start is accepted
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, combinational from mem_addr in the same cycle
- res_valid  out  1  classification valid
- res_ready  in  1  consumer accepts classification
- res_addr  out  ADDR_W  word address of the result
- res_flip  out  1  word classified flip
- res_patch  out  1  word classified patch
- busy  out  1  run in progress
- done  out  1  run complete; high in DONE
- cnt_ok  out  ADDR_W+1  accepted ok words
- cnt_flip  out  ADDR_W+1  accepted flip words
- cnt_patch  out  ADDR_W+1  accepted patch words

Behaviour:
- Reset:
  - State IDLE; outputs mem_we, mem_addr, mem_wdata, res_valid, res_addr, res_flip, res_patch, busy, done all 0.
  - Counters 0; internal pattern index and accumulators 0.
- Pattern order (index p):
  - p=0: all ones
  - p=1: all zeros
  - p=2: alternating, MSB=1 (0xAAAA at DATA_W=16)
  - p=3: inverse of p=2
  - Only p < N_PAT are applied.
- States: IDLE, WRITE, READ, EMIT, DONE.
- IDLE/DONE, start=1:
  - Latch base/last; clear counters and accumulators; p=0; done=0; busy=1.
  - If last_addr < base_addr, go to DONE next cycle without any memory access.
  - Otherwise go to WRITE with mem_addr=base_addr.
- WRITE (1 cycle): mem_we=1, mem_wdata=pattern p, mem_addr=current address. Go to READ.
- READ (1 cycle):
  - mem_we=0, same address.
  - diff = mem_rdata XOR pattern p.
  - hi_err = OR of diff[DATA_W-1 : DATA_W-HIGH_W]; lo_err = OR of diff[DATA_W-HIGH_W-1 : 0].
  - Accumulate patch_acc |= lo_err and hi_acc |= hi_err.
  - If p < N_PAT-1: p++ and go to WRITE. Otherwise go to EMIT.
- EMIT:
  - res_valid=1, res_addr=current address, res_patch=patch_acc, res_flip=hi_acc AND NOT patch_acc. Flip and patch are never both 1.
  - mem_we=0; mem_addr is held.
  - All res_* are held stable while res_ready=0.
  - On res_valid AND res_ready: increment exactly one of cnt_ok / cnt_flip / cnt_patch, then clear accumulators and set p=0.
  - If address == last_addr: go to DONE. Otherwise address+1 and go to WRITE.
- DONE: done=1, busy=0, res_valid=0; counters hold until the next accepted start or reset.
- Start while busy (WRITE/READ/EMIT) is ignored; base/last changes during a run are ignored.
- Cycles per word = 2*N_PAT + 1 when res_ready=1; each cycle of backpressure adds one.
- Range ending at address 2^ADDR_W-1: stop on the equality compare; the address never wraps.
- Reset asserted in any state returns all outputs to reset values on the next edge; a partially emitted result is discarded.

Test Plan:
- Fault-free RAM, DATA_W=16, HIGH_W=8, N_PAT=2, base=0, last=15, res_ready=1 -> 16 results in address order, all flip=0/patch=0. cnt_ok=16; done rises 80 cycles after start is accepted (+1 for DONE entry); every write is 0xFFFF then 0x0000.
- Stuck-at-1 on bit 15 of addr 3 (same setup) -> addr 3 gives flip=1, patch=0; final cnt_ok=15, cnt_flip=1, cnt_patch=0.
- Stuck-at-0 on bit 0 of addr 5 plus stuck-at-1 on bit 12 of addr 5 -> addr 5 gives patch=1, flip=0 (patch dominates); cnt_patch=1.
- N_PAT=4, stuck-at-0 on bit 14 of addr 2 -> wdata sequence per word is FFFF, 0000, AAAA, 5555; addr 2 gives flip=1; 9 cycles per word.
- Backpressure: hold res_ready=0 for 3 cycles at addr 7 -> res_valid, res_addr=7 and flags stable for 3 cycles; mem_we=0; counters unchanged until the accepting edge.
- base=10, last=4 -> DONE one cycle after start, no mem_we, counters 0. Separately, assert reset during READ of addr 6 -> all outputs 0 next cycle; a subsequent start reruns cleanly from base_addr.

Source files
------------

// File: rtl/march_fault_classifier.sv
// March engine: writes and reads back up to four data patterns per word of an address
// range, then streams one ok/flip/patch classification per word with running totals.
module march_fault_classifier #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int HIGH_W = 8,
  parameter int N_PAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_flip,
  output logic              res_patch,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   cnt_ok,
  output logic [ADDR_W:0]   cnt_flip,
  output logic [ADDR_W:0]   cnt_patch
);

  localparam int         LOW_W    = DATA_W - HIGH_W;
  localparam logic [1:0] LAST_PAT = 2'(N_PAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] last_r;
  logic [1:0]        pat_idx_r;
  logic              hi_acc_r;
  logic              patch_acc_r;

  logic [DATA_W-1:0] diff_s;
  logic              hi_err_s;
  logic              lo_err_s;
  logic              hi_any_s;
  logic              patch_any_s;

  // Pattern p: ones, zeros, alternating with MSB set, and its inverse.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] idx);
    logic [DATA_W-1:0] alt;
    for (int i = 0; i < DATA_W; i++) begin
      alt[i] = ~1'(DATA_W - 1 - i);
    end
    case (idx)
      2'd0:    pattern = {DATA_W{1'b1}};
      2'd1:    pattern = {DATA_W{1'b0}};
      2'd2:    pattern = alt;
      2'd3:    pattern = ~alt;
      default: pattern = {DATA_W{1'b0}};
    endcase
  endfunction

  // Read-back comparison for the current pattern, merged with earlier patterns of this word.
  always_comb begin
    diff_s      = mem_rdata ^ pattern(pat_idx_r);
    hi_err_s    = |diff_s[DATA_W-1 -: HIGH_W];
    lo_err_s    = |diff_s[LOW_W-1:0];
    hi_any_s    = hi_acc_r | hi_err_s;
    patch_any_s = patch_acc_r | lo_err_s;
  end

  // Sequencer with registered memory port, result port and running totals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      last_r      <= {ADDR_W{1'b0}};
      pat_idx_r   <= 2'd0;
      hi_acc_r    <= 1'b0;
      patch_acc_r <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
      res_valid   <= 1'b0;
      res_addr    <= {ADDR_W{1'b0}};
      res_flip    <= 1'b0;
      res_patch   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cnt_ok      <= {(ADDR_W+1){1'b0}};
      cnt_flip    <= {(ADDR_W+1){1'b0}};
      cnt_patch   <= {(ADDR_W+1){1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            last_r      <= last_addr;
            addr_r      <= base_addr;
            pat_idx_r   <= 2'd0;
            hi_acc_r    <= 1'b0;
            patch_acc_r <= 1'b0;
            cnt_ok      <= {(ADDR_W+1){1'b0}};
            cnt_flip    <= {(ADDR_W+1){1'b0}};
            cnt_patch   <= {(ADDR_W+1){1'b0}};
            res_valid   <= 1'b0;
            // An empty range completes at once and never touches memory.
            if (last_addr < base_addr) begin
              state_r <= DONE;
              mem_we  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r   <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= base_addr;
              mem_wdata <= pattern(2'd0);
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        WRITE: begin
          state_r <= READ;
          mem_we  <= 1'b0;
        end
        READ: begin
          hi_acc_r    <= hi_any_s;
          patch_acc_r <= patch_any_s;
          if (pat_idx_r == LAST_PAT) begin
            state_r   <= EMIT;
            res_valid <= 1'b1;
            res_addr  <= addr_r;
            res_patch <= patch_any_s;
            res_flip  <= hi_any_s & ~patch_any_s;
          end else begin
            state_r   <= WRITE;
            pat_idx_r <= pat_idx_r + 2'd1;
            mem_wdata <= pattern(pat_idx_r + 2'd1);
            mem_we    <= 1'b1;
          end
        end
        EMIT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            hi_acc_r    <= 1'b0;
            patch_acc_r <= 1'b0;
            pat_idx_r   <= 2'd0;
            if (res_patch) begin
              cnt_patch <= cnt_patch + (ADDR_W+1)'(1'b1);
            end else if (res_flip) begin
              cnt_flip <= cnt_flip + (ADDR_W+1)'(1'b1);
            end else begin
              cnt_ok <= cnt_ok + (ADDR_W+1)'(1'b1);
            end
            // Equality stop means a range ending at the top address never wraps.
            if (addr_r == last_r) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r   <= WRITE;
              addr_r    <= addr_r + ADDR_W'(1'b1);
              mem_addr  <= addr_r + ADDR_W'(1'b1);
              mem_wdata <= pattern(2'd0);
              mem_we    <= 1'b1;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_we    <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_fault_classifier.sv
// Bench for march_fault_classifier: two instances (2 and 4 patterns) on fault-injecting RAM models.
module tb_march_fault_classifier;

  logic clk;
  logic reset;

  logic        start     [2];
  logic [19:0] base_addr [2];
  logic [19:0] last_addr [2];
  logic        mem_we    [2];
  logic [19:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [19:0] res_addr  [2];
  logic        res_flip  [2];
  logic        res_patch [2];
  logic        busy      [2];
  logic        done      [2];
  logic [20:0] cnt_ok    [2];
  logic [20:0] cnt_flip  [2];
  logic [20:0] cnt_patch [2];

  logic [15:0] mem [2][64];
  logic [15:0] sa1 [2][64];
  logic [15:0] sa0 [2][64];
  logic [15:0] pat_tab [4] = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555};

  int n_checks = 0;
  int n_fail   = 0;

  march_fault_classifier #(.DATA_W(16), .ADDR_W(20), .HIGH_W(8), .N_PAT(2)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .base_addr(base_addr[0]), .last_addr(last_addr[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_addr(res_addr[0]),
    .res_flip(res_flip[0]), .res_patch(res_patch[0]), .busy(busy[0]), .done(done[0]),
    .cnt_ok(cnt_ok[0]), .cnt_flip(cnt_flip[0]), .cnt_patch(cnt_patch[0]));

  march_fault_classifier #(.DATA_W(16), .ADDR_W(20), .HIGH_W(8), .N_PAT(4)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .base_addr(base_addr[1]), .last_addr(last_addr[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_addr(res_addr[1]),
    .res_flip(res_flip[1]), .res_patch(res_patch[1]), .busy(busy[1]), .done(done[1]),
    .cnt_ok(cnt_ok[1]), .cnt_flip(cnt_flip[1]), .cnt_patch(cnt_patch[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: 64 aliased words each, stuck-at bits applied on the combinational read path.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = (mem[k][mem_addr[k][5:0]] | sa1[k][mem_addr[k][5:0]]) & ~sa0[k][mem_addr[k][5:0]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) mem[k][mem_addr[k][5:0]] <= mem_wdata[k];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: 0 ok, 1 flip, 2 patch, from the stuck-at masks and the pattern list.
  function automatic int classify(input int k, input logic [19:0] a);
    logic [15:0] rd, e;
    bit lo, hi;
    int np;
    np = (k == 0) ? 2 : 4;
    lo = 1'b0;
    hi = 1'b0;
    for (int p = 0; p < np; p++) begin
      rd = (pat_tab[p] | sa1[k][a[5:0]]) & ~sa0[k][a[5:0]];
      e  = rd ^ pat_tab[p];
      if (e[7:0] != 8'h00) lo = 1'b1;
      if (e[15:8] != 8'h00) hi = 1'b1;
    end
    return lo ? 2 : (hi ? 1 : 0);
  endfunction

  task automatic clear_faults();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) begin
        sa1[k][i] = 16'h0000;
        sa0[k][i] = 16'h0000;
      end
    end
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_mem_we", mem_we[k], 1'b0);
    check("rst_mem_addr", mem_addr[k], 20'h0);
    check("rst_mem_wdata", mem_wdata[k], 16'h0);
    check("rst_res_valid", res_valid[k], 1'b0);
    check("rst_res_addr", res_addr[k], 20'h0);
    check("rst_res_flags", {res_flip[k], res_patch[k]}, 2'b00);
    check("rst_busy_done", {busy[k], done[k]}, 2'b00);
    check("rst_counters", {cnt_ok[k], cnt_flip[k], cnt_patch[k]}, 63'h0);
  endtask

  task automatic run(input int k, input logic [19:0] base, input logic [19:0] last, input int pct);
    int npat, cyc, stalls, words, nres, wr_idx, c, e_ok, e_fl, e_pa;
    logic [19:0] exp_addr;
    npat  = (k == 0) ? 2 : 4;
    words = (last >= base) ? int'(last - base) + 1 : 0;
    e_ok = 0; e_fl = 0; e_pa = 0;
    for (int i = 0; i < words; i++) begin
      c = classify(k, base + 20'(i));
      if (c == 2) e_pa++; else if (c == 1) e_fl++; else e_ok++;
    end
    base_addr[k] = base;
    last_addr[k] = last;
    res_ready[k] = 1'b1;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    cyc = 0; stalls = 0; nres = 0; wr_idx = 0;
    exp_addr = base;
    while (!done[k] && cyc < 4000) begin
      if (mem_we[k]) begin
        check("wdata", mem_wdata[k], pat_tab[wr_idx % npat]);
        check("wr_addr", mem_addr[k], exp_addr);
        wr_idx++;
      end
      res_ready[k] = ($urandom_range(0, 99) < pct);
      if (res_valid[k]) begin
        if (res_ready[k]) begin
          c = classify(k, exp_addr);
          check("res_addr", res_addr[k], exp_addr);
          check("res_flip", res_flip[k], (c == 1));
          check("res_patch", res_patch[k], (c == 2));
          nres++;
          exp_addr = exp_addr + 20'd1;
        end else begin
          stalls++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    res_ready[k] = 1'b1;
    check("done_reached", done[k], 1'b1);
    check("busy_after", busy[k], 1'b0);
    check("no_we_in_done", mem_we[k], 1'b0);
    check("cycles", cyc, words * (2 * npat + 1) + stalls);
    check("n_results", nres, words);
    check("n_writes", wr_idx, words * npat);
    check("cnt_ok_model", cnt_ok[k], e_ok);
    check("cnt_flip_model", cnt_flip[k], e_fl);
    check("cnt_patch_model", cnt_patch[k], e_pa);
  endtask

  typedef struct {
    int          k;
    logic [19:0] base;
    logic [19:0] last;
    int          fidx;
    logic [15:0] s1;
    logic [15:0] s0;
    int          ok;
    int          fl;
    int          pa;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int w;
    tbl[0] = '{0, 20'h00000, 20'h0000F, -1, 16'h0000, 16'h0000, 16, 0, 0};
    tbl[1] = '{0, 20'h00000, 20'h0000F,  3, 16'h8000, 16'h0000, 15, 1, 0};
    tbl[2] = '{0, 20'h00000, 20'h0000F,  5, 16'h1000, 16'h0001, 15, 0, 1};
    tbl[3] = '{1, 20'h00000, 20'h0000F,  2, 16'h0000, 16'h4000, 15, 1, 0};
    tbl[4] = '{0, 20'h0000A, 20'h00004, -1, 16'h0000, 16'h0000,  0, 0, 0};
    tbl[5] = '{1, 20'h00000, 20'h00003,  0, 16'h0008, 16'h0000,  3, 0, 1};
    tbl[6] = '{0, 20'hFFFFC, 20'hFFFFF, 63, 16'h0100, 16'h0000,  3, 1, 0};

    clear_faults();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; base_addr[k] = 20'h0; last_addr[k] = 20'h0; res_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int t = 0; t < 7; t++) begin
      clear_faults();
      if (tbl[t].fidx >= 0) begin
        sa1[tbl[t].k][tbl[t].fidx] = tbl[t].s1;
        sa0[tbl[t].k][tbl[t].fidx] = tbl[t].s0;
      end
      run(tbl[t].k, tbl[t].base, tbl[t].last, 100);
      check("tbl_cnt_ok", cnt_ok[tbl[t].k], tbl[t].ok);
      check("tbl_cnt_flip", cnt_flip[tbl[t].k], tbl[t].fl);
      check("tbl_cnt_patch", cnt_patch[tbl[t].k], tbl[t].pa);
    end

    // Backpressure at address 7 (flip fault there)
    clear_faults();
    sa1[0][7] = 16'h8000;
    base_addr[0] = 20'h0; last_addr[0] = 20'hF; res_ready[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    w = 0;
    while (!(res_valid[0] && res_addr[0] == 20'd7) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("bp_reach", {res_valid[0], res_addr[0]}, {1'b1, 20'd7});
    res_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid", res_valid[0], 1'b1);
      check("bp_addr", res_addr[0], 20'd7);
      check("bp_flags", {res_flip[0], res_patch[0]}, 2'b10);
      check("bp_mem_we", mem_we[0], 1'b0);
      check("bp_counts", {cnt_ok[0], cnt_flip[0], cnt_patch[0]}, {21'd7, 21'd0, 21'd0});
    end
    res_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_accept_valid", res_valid[0], 1'b0);
    check("bp_accept_flip", cnt_flip[0], 21'd1);
    w = 0;
    while (!done[0] && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("bp_done", done[0], 1'b1);
    check("bp_final", {cnt_ok[0], cnt_flip[0], cnt_patch[0]}, {21'd15, 21'd1, 21'd0});

    // Reset during READ of address 6, then a clean rerun
    clear_faults();
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    w = 0;
    while (!(busy[0] && !mem_we[0] && !res_valid[0] && mem_addr[0] == 20'd6) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("rd6_reach", {busy[0], mem_we[0], mem_addr[0]}, {1'b1, 1'b0, 20'd6});
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs(0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {busy[0], done[0], res_valid[0]}, 3'b000);
    run(0, 20'h0, 20'hF, 100);
    check("rerun_ok", cnt_ok[0], 21'd16);

    // Randomized faults, ranges and backpressure
    for (int r = 0; r < 8; r++) begin
      int k;
      logic [19:0] b;
      k = r % 2;
      clear_faults();
      for (int f = 0; f < 5; f++) begin
        int idx;
        idx = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1)
          sa1[k][idx] = sa1[k][idx] | 16'(32'h1 << $urandom_range(0, 15));
        else
          sa0[k][idx] = sa0[k][idx] | 16'(32'h1 << $urandom_range(0, 15));
      end
      b = 20'($urandom_range(0, 20));
      run(k, b, b + 20'($urandom_range(0, 12)), 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
